mac_array_acc: RTL and testbench
================================

Name: mac_array_acc

Overview:
Parametrised multi-lane multiply-accumulate engine for dot-product and neuron evaluation.
- LANES independent signed MAC lanes share one valid/ready input stream and a beat counter.
- Each lane accumulates VEC_LEN products onto a per-lane bias, with optional saturation.
- Results are presented on a valid/ready output port. Sits between the operand fetch buffers and the activation stage.

Parameters:
DATA_WIDTH, 8, signed operand width per lane
ACC_WIDTH, 32, signed accumulator/result width per lane; must be >= 2*DATA_WIDTH
LANES, 4, number of parallel MAC lanes
LEN_W, 16, width of vector-length field

Ports:
clk  input  1  clock; all flops on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin new dot product; sampled only in IDLE
vec_len  input  LEN_W  beats to accumulate; latched on start
bias  input  LANES*ACC_WIDTH  per-lane initial accumulator; latched on start; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
sat_en  input  1  1 = saturate, 0 = wrap; latched on start
in_valid  input  1  operand beat valid
in_ready  output  1  engine accepts a beat
operand_a  input  LANES*DATA_WIDTH  signed operand per lane
operand_b  input  LANES*DATA_WIDTH  signed operand per lane
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  LANES*ACC_WIDTH  per-lane accumulated result
overflow  output  LANES  sticky per-lane overflow flag; valid with out_data
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. in_ready, out_valid, busy and overflow = 0. out_data, accumulators, product registers, beat counter and product-valid = 0. Reset mid-operation abandons the job; no partial result is ever emitted.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1, vec_len!=0: latch vec_len and sat_en; acc[i] <= bias[i]; clear overflow and counter; go to ACCUM.
  - start=1, vec_len==0: acc <= bias; overflow cleared; go to DONE.
- ACCUM: in_ready=1. A beat is accepted on an edge with in_valid && in_ready.
  - Accepting a beat increments the counter.
  - The beat's products are registered in stage 1: p[i] = a[i]*b[i], full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; p_valid=1.
  - When the accepted beat makes counter==vec_len, go to DRAIN. in_ready is 0 from that edge.
  - in_valid gaps are allowed; no beat is lost or duplicated.
- Stage 2, every edge with p_valid=1: acc[i] <= acc[i] + p[i].
  - Sum is computed at ACC_WIDTH+1 bits.
  - On signed overflow, set overflow[i] (sticky).
  - With sat_en=1, clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1). With sat_en=0, keep the wrapped ACC_WIDTH result.
- DRAIN: lasts one cycle, during which the final product is accumulated. Then go to DONE.
- Latency: final beat accepted at edge E; acc final at edge E+1; out_valid=1 from edge E+1.
- DONE:
  - out_valid=1, out_data = acc. out_data and overflow stay stable while out_valid && !out_ready.
  - On edge with out_ready=1: go to IDLE, out_valid=0. out_data holds its last value.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored; in_ready=0.
- Lanes are fully independent. Overflow in one lane never affects another.
- Extreme products: the -2^(DATA_WIDTH-1) * -2^(DATA_WIDTH-1) product is exact and never overflows the product register.

Test Plan:
1. Basic dot product: vec_len=3, bias=0, sat_en=1. Lane0 a=(2,3,-4), b=(5,6,7). Lane1 a=b=127 for all 3 beats. Lanes 2/3 a=b=-128. -> out_data lane0=0, lane1=48387, lanes2/3=49152, overflow=0. out_valid rises 2 edges after the 3rd accept edge, counting that edge.
2. Backpressure: same stimulus, in_valid low for 2 cycles between beats, out_ready low for 5 cycles. -> identical results; out_data stable while stalled; single out_valid handshake.
3. Saturation (ACC_WIDTH=16, DATA_WIDTH=8): bias lane0=32767, a=1, b=1, vec_len=1.
   - sat_en=1 -> 32767, overflow[0]=1.
   - sat_en=0 -> -32768, overflow[0]=1.
   - bias=-32768, a=-1, b=1, sat_en=1 -> -32768, overflow=1.
4. vec_len=0 with bias lane0=-5 -> out_valid next cycle with lane0=-5; in_ready never asserts.
5. Reset mid-job: vec_len=4, assert rst_n=0 after 2 beats. -> busy, in_ready, out_valid drop immediately without a clock. A following job with vec_len=1, a=3, b=4, bias=0 gives 12.
6. start pulsed while busy -> ignored. In-flight result unchanged. Next start after out handshake is accepted.

Source files
------------

// File: rtl/mac_array_acc.sv
// mac_array_acc: multi-lane signed multiply-accumulate engine.
//   Each lane adds VEC_LEN products a*b onto a per-lane bias. It can either
//   saturate or wrap on overflow, and it keeps a sticky overflow flag.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     start, vec_len, bias,   job setup, sampled in IDLE only
//       sat_en
//     in_valid/in_ready,      operand beat stream, shared by all lanes
//       operand_a/b
//     out_valid/out_ready,    result handshake
//       out_data, overflow
//     busy                    high whenever the engine is not IDLE
//   Pipeline: beat accept -> product register (stage 1) -> accumulate (stage 2).

// ---------------------------------------------------------------------------
// One MAC lane: product register, accumulator, sticky overflow, result reg.
// ---------------------------------------------------------------------------
module mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,   // job start: acc <= bias, clear ovf
  input  logic                  i_beat,   // beat accepted: register product
  input  logic                  i_pvld,   // product register holds a live term
  input  logic                  i_sat,
  input  logic                  i_cap,    // latch result into output register
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [ACC_WIDTH-1:0]  i_bias,
  output logic [ACC_WIDTH-1:0]  o_data,
  output logic                  o_ovf
);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    r_prod;
  logic        [ACC_WIDTH-1:0]    r_acc;
  logic        [ACC_WIDTH:0]      w_sum;
  logic                           w_ovf;
  logic        [ACC_WIDTH-1:0]    w_acc_nxt;
  logic        [ACC_WIDTH-1:0]    r_out;
  logic                           r_ovf;

  // Full-width product: even (-2^(N-1))^2 fits exactly in 2*N signed bits.
  assign w_prod = $signed(i_a) * $signed(i_b);

  // One guard bit; the top two bits of the sum disagree on signed overflow.
  assign w_sum = {r_acc[ACC_WIDTH-1], r_acc} + {r_prod[ACC_WIDTH-1], r_prod};
  assign w_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_acc_nxt = r_acc;
    if (i_pvld) begin
      if (w_ovf && i_sat) w_acc_nxt = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else                w_acc_nxt = w_sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_out  <= '0;
    end else begin
      if (i_beat) r_prod <= ACC_WIDTH'(w_prod);   // signed cast sign-extends
      if (i_load) begin
        r_acc <= i_bias;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_acc_nxt;
        if (i_pvld && w_ovf) r_ovf <= 1'b1;
      end
      // A zero-length job presents the bias directly as the result.
      if (i_cap) r_out <= i_load ? i_bias : w_acc_nxt;
    end
  end

  assign o_data = r_out;
  assign o_ovf  = r_ovf;
endmodule

// ---------------------------------------------------------------------------
// Top: job FSM, beat counter, lane array.
// ---------------------------------------------------------------------------
module mac_array_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,   // must be >= 2*DATA_WIDTH
  parameter int LANES      = 4,
  parameter int LEN_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            vec_len,
  input  logic [LANES*ACC_WIDTH-1:0]  bias,
  input  logic                        sat_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] operand_a,
  input  logic [LANES*DATA_WIDTH-1:0] operand_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  out_data,
  output logic [LANES-1:0]            overflow,
  output logic                        busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_pvld;

  logic             w_accept;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_load;
  logic             w_cap;

  assign w_accept  = in_valid && r_in_ready;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = w_accept && (w_cnt_inc == r_len);
  assign w_load    = (r_state == S_IDLE) && start;
  // Result is latched when the last product lands (DRAIN), or at start for
  // an empty job.
  assign w_cap     = (r_state == S_DRAIN) || (w_load && (vec_len == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_pvld      <= 1'b0;
    end else begin
      r_pvld <= w_accept;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len  <= vec_len;
            r_sat  <= sat_en;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (vec_len == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_beat (w_accept),
      .i_pvld (r_pvld),
      .i_sat  (r_sat),
      .i_cap  (w_cap),
      .i_a    (operand_a[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_b    (operand_b[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_bias (bias[g*ACC_WIDTH +: ACC_WIDTH]),
      .o_data (out_data[g*ACC_WIDTH +: ACC_WIDTH]),
      .o_ovf  (overflow[g])
    );
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
endmodule

// File: tb/tb_mac_array_acc.sv
// Self-checking bench for mac_array_acc: directed scenarios and randomized
// jobs, all compared against a plain-arithmetic reference model.
module tb_mac_array_acc;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int LW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LW-1:0]     vec_len = '0;
  logic [L*AW-1:0]   bias = '0;
  logic              sat_en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [L*DW-1:0]   operand_a = '0;
  logic [L*DW-1:0]   operand_b = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [L*AW-1:0]   out_data;
  logic [L-1:0]      overflow;
  logic              busy;

  mac_array_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .bias(bias),
    .sat_en(sat_en), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Job description (shared with the model) and expected results.
  int          ta [0:15][0:L-1];
  int          tb [0:15][0:L-1];
  longint      tbias [0:L-1];
  logic [31:0] exp_res [0:L-1];
  logic        exp_ov  [0:L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a running sum in wide integer arithmetic with the clamp/wrap
  // rule applied after every term.
  task automatic model(input int len, input bit sat);
    for (int l = 0; l < L; l++) begin
      longint acc = tbias[l];
      bit     o = 1'b0;
      for (int k = 0; k < len; k++) begin
        longint s = acc + longint'(ta[k][l]) * longint'(tb[k][l]);
        if (s > MAXV) begin
          o = 1'b1; acc = sat ? MAXV : s - 64'sd4294967296;
        end else if (s < MINV) begin
          o = 1'b1; acc = sat ? MINV : s + 64'sd4294967296;
        end else acc = s;
      end
      exp_res[l] = acc[31:0];
      exp_ov[l]  = o;
    end
  endtask

  task automatic check_out(input string tag);
    for (int l = 0; l < L; l++) begin
      check($sformatf("%s_data%0d", tag, l), 64'(out_data[l*AW +: AW]), 64'(exp_res[l]));
      check($sformatf("%s_ovf%0d", tag, l), 64'(overflow[l]), 64'(exp_ov[l]));
    end
  endtask

  task automatic drive_beat(input int k);
    for (int l = 0; l < L; l++) begin
      operand_a[l*DW +: DW] = DW'(ta[k][l]);
      operand_b[l*DW +: DW] = DW'(tb[k][l]);
    end
  endtask

  // gap_mode: 0 none, 1 two idle cycles after each beat, 2 random gaps.
  // poke: pulse start (with junk setup) while the job is in flight.
  task automatic run_job(input string tag, input int len, input bit sat,
                         input int gap_mode, input int stall, input bit poke);
    int idx = 0;
    int guard = 0;
    int hold = 0;
    bit gap;
    model(len, sat);
    start = 1'b1; vec_len = LW'(len); sat_en = sat;
    for (int l = 0; l < L; l++) bias[l*AW +: AW] = tbias[l][31:0];
    @(negedge clk);
    // Scramble setup inputs: only the values at the start edge may matter.
    start = 1'b0; vec_len = LW'($urandom()); sat_en = ~sat; bias = {L{$urandom()}};
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_rdy0"}, 64'(in_ready), 64'(len != 0));
    while (idx < len && guard < 1000) begin
      if (gap_mode == 1) gap = (hold > 0);
      else if (gap_mode == 2) gap = ($urandom_range(0, 2) == 0);
      else gap = 1'b0;
      if (gap) begin
        hold--;
        in_valid = 1'b0;
        operand_a = $urandom(); operand_b = $urandom();
      end else begin
        in_valid = 1'b1;
        drive_beat(idx);
      end
      start = poke && ($urandom_range(0, 3) == 0);
      if (!gap && in_ready) begin
        idx++;
        hold = 2;
      end
      guard++;
      @(negedge clk);
    end
    if (guard >= 1000) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    in_valid = 1'b0; start = 1'b0;
    if (len > 0) begin
      // One cycle after the last accept edge: still draining.
      check({tag, "_drain_ov"}, 64'(out_valid), 64'd0);
      check({tag, "_drain_rdy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    check({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      start = poke;
      check_out({tag, "_stall"});
      check({tag, "_stall_ov"}, 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check_out(tag);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_ov"}, 64'(out_valid), 64'd0);
    check({tag, "_post_busy"}, 64'(busy), 64'd0);
    check_out({tag, "_hold"});
  endtask

  task automatic clear_job();
    for (int k = 0; k < 16; k++)
      for (int l = 0; l < L; l++) begin ta[k][l] = 0; tb[k][l] = 0; end
    for (int l = 0; l < L; l++) tbias[l] = 0;
  endtask

  task automatic load_basic();
    clear_job();
    ta[0][0] = 2;  ta[1][0] = 3;  ta[2][0] = -4;
    tb[0][0] = 5;  tb[1][0] = 6;  tb[2][0] = 7;
    for (int k = 0; k < 3; k++) begin
      ta[k][1] = 127;  tb[k][1] = 127;
      ta[k][2] = -128; tb[k][2] = -128;
      ta[k][3] = -128; tb[k][3] = -128;
    end
  endtask

  initial begin #500000; $display("FAIL watchdog timeout"); $fatal(1); end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd0);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product, then the same with gaps, backpressure and pokes.
    load_basic();
    run_job("t1", 3, 1'b1, 0, 0, 1'b0);
    check("t1_lit0", 64'(out_data[31:0]), 64'd0);
    check("t1_lit1", 64'(out_data[63:32]), 64'd48387);
    check("t1_lit2", 64'(out_data[95:64]), 64'd49152);
    check("t1_lit3", 64'(out_data[127:96]), 64'd49152);
    run_job("t2", 3, 1'b1, 1, 5, 1'b0);
    run_job("t6", 3, 1'b1, 2, 3, 1'b1);

    // Saturation / wrap at the accumulator limits.
    clear_job(); tbias[0] = MAXV; ta[0][0] = 1; tb[0][0] = 1;
    run_job("sat_hi", 1, 1'b1, 0, 1, 1'b0);
    check("sat_hi_lit", 64'(out_data[31:0]), 64'h7FFFFFFF);
    run_job("wrap_hi", 1, 1'b0, 0, 0, 1'b0);
    check("wrap_hi_lit", 64'(out_data[31:0]), 64'h80000000);
    clear_job(); tbias[0] = MINV; ta[0][0] = -1; tb[0][0] = 1;
    run_job("sat_lo", 1, 1'b1, 0, 0, 1'b0);
    check("sat_lo_lit", 64'(out_data[31:0]), 64'h80000000);

    // Empty job.
    clear_job(); tbias[0] = -5;
    run_job("len0", 0, 1'b1, 0, 2, 1'b0);
    check("len0_lit", 64'(out_data[31:0]), 64'hFFFFFFFB);

    // Reset in the middle of a job.
    clear_job();
    start = 1'b1; vec_len = 16'd4; sat_en = 1'b1; bias = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; operand_a = {L{8'sd9}}; operand_b = {L{8'sd9}};
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd0);
    check("mid_rst_ovalid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int l = 0; l < L; l++) begin ta[0][l] = 3; tb[0][l] = 4; end
    run_job("after_rst", 1, 1'b1, 0, 0, 1'b0);
    check("after_rst_lit", 64'(out_data[31:0]), 64'd12);

    // Randomized jobs, biases often placed near the limits.
    for (int j = 0; j < 10; j++) begin
      int len = $urandom_range(1, 12);
      clear_job();
      for (int k = 0; k < len; k++)
        for (int l = 0; l < L; l++) begin
          ta[k][l] = int'($urandom_range(0, 255)) - 128;
          tb[k][l] = int'($urandom_range(0, 255)) - 128;
        end
      for (int l = 0; l < L; l++) begin
        case ($urandom_range(0, 2))
          0: tbias[l] = MAXV - longint'($urandom_range(0, 200000));
          1: tbias[l] = MINV + longint'($urandom_range(0, 200000));
          default: tbias[l] = longint'(int'($urandom()));
        endcase
      end
      run_job($sformatf("rnd%0d", j), len, 1'($urandom_range(0, 1)),
              j % 3, $urandom_range(0, 4), (j % 2) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
